if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline; the producer side of the IF/ID pipeline register. Holds the PC, issues requests to instruction memory over a req/ack handshake, and presents one fetched instruction with its PC+4 in an output slot. IF/ID captures that slot when it is valid and not stalled. Honours pipeline stall and branch/jump redirect, including a redirect that arrives while a memory request is still outstanding.

---
 rtl/if_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// level req / ack handshake and presents one fetched instruction (with its
// PC+4) in an output slot for the IF/ID register to capture.
//
// Handshakes:
//   memory : ImemReq_o is a level; once high, ImemAddr_o is held stable until
//            ImemAck_i=1, which may arrive in the first cycle the request is
//            visible. ImemData_i is sampled on the edge where ImemAck_i=1.
//   slot   : the slot is consumed on every edge with Valid_o=1 and Stall_i=0.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clock_i,
   input  logic        Reset_n_i,
   input  logic        Stall_i,
   input  logic        Redirect_i,
   input  logic [31:0] Target_i,
   output logic        ImemReq_o,
   output logic [31:0] ImemAddr_o,
   input  logic        ImemAck_i,
   input  logic [31:0] ImemData_i,
   output logic [31:0] PC4_o,
   output logic [31:0] Inst_o,
   output logic        Valid_o
);

   // IDLE : no request; waiting for the slot to free up.
   // FETCH: request outstanding; its data is wanted.
   // DRAIN: request outstanding but made stale by a redirect; data dropped.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_addr;
   logic        r_valid;
   logic [31:0] r_pc4;
   logic [31:0] r_inst;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_req_addr_nxt;
   logic        w_valid_nxt;
   logic [31:0] w_pc4_nxt;
   logic [31:0] w_inst_nxt;

   logic [31:0] w_target;
   logic [31:0] w_req_addr_p4;
   logic        w_consume;

   assign w_target      = Target_i & ~32'd3;
   assign w_req_addr_p4 = r_req_addr + 32'd4;
   assign w_consume     = r_valid & ~Stall_i;

   // Request is a pure decode of the state register (no input-to-output path).
   assign ImemReq_o  = (r_state != ST_IDLE);
   assign ImemAddr_o = r_req_addr;
   assign PC4_o      = r_pc4;
   assign Inst_o     = r_inst;
   assign Valid_o    = r_valid;

   // Next-state and datapath decode; redirect outranks ack, ack outranks consumption.
   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_addr_nxt = r_req_addr;
      w_valid_nxt    = r_valid & ~w_consume;
      w_pc4_nxt      = r_pc4;
      w_inst_nxt     = r_inst;

      if (Redirect_i) begin
         // Flush the slot and retarget; an in-flight request cannot be moved,
         // so FETCH without ack has to drain the stale transaction first.
         w_pc_nxt    = w_target;
         w_valid_nxt = 1'b0;
         w_pc4_nxt   = 32'd0;
         w_inst_nxt  = 32'd0;
         case (r_state)
            ST_IDLE: begin
               w_state_nxt    = ST_FETCH;
               w_req_addr_nxt = w_target;
            end
            ST_FETCH: begin
               if (ImemAck_i) begin
                  w_req_addr_nxt = w_target;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (ImemAck_i) begin
                  w_state_nxt    = ST_FETCH;
                  w_req_addr_nxt = w_target;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!r_valid || w_consume) begin
                  w_state_nxt    = ST_FETCH;
                  w_req_addr_nxt = r_pc;
               end
            end
            ST_FETCH: begin
               if (ImemAck_i) begin
                  w_inst_nxt  = ImemData_i;
                  w_pc4_nxt   = w_req_addr_p4;
                  w_valid_nxt = 1'b1;
                  w_pc_nxt    = w_req_addr_p4;
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               // Stale data is dropped; PC already holds the redirect target.
               if (ImemAck_i) begin
                  w_state_nxt    = ST_FETCH;
                  w_req_addr_nxt = r_pc;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge Clock_i) begin
      if (!Reset_n_i) begin
         r_state    <= ST_IDLE;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_valid    <= 1'b0;
         r_pc4      <= 32'd0;
         r_inst     <= 32'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_req_addr <= w_req_addr_nxt;
         r_valid    <= w_valid_nxt;
         r_pc4      <= w_pc4_nxt;
         r_inst     <= w_inst_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a vector table walks the main DUT through
// fetch, stall, redirect (idle / in-flight / drain / coincident ack), stall
// with redirect, and reset mid-request; a second instance with
// RESET_PC=FFFF_FFFC covers PC+4 wrap-around.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redir;
   logic [31:0] target;
   logic        ack;
   logic [31:0] data;
   logic        req;
   logic [31:0] addr;
   logic [31:0] pc4;
   logic [31:0] inst;
   logic        valid;

   logic        w_rst_n;
   logic        w_stall;
   logic        w_redir;
   logic [31:0] w_target;
   logic        w_ack;
   logic [31:0] w_data;
   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_pc4;
   logic [31:0] w_inst;
   logic        w_valid;

   int n_checks;
   int n_pass;

   if_fetch_unit u_dut (
      .Clock_i    (clk),
      .Reset_n_i  (rst_n),
      .Stall_i    (stall),
      .Redirect_i (redir),
      .Target_i   (target),
      .ImemReq_o  (req),
      .ImemAddr_o (addr),
      .ImemAck_i  (ack),
      .ImemData_i (data),
      .PC4_o      (pc4),
      .Inst_o     (inst),
      .Valid_o    (valid)
   );

   if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .Clock_i    (clk),
      .Reset_n_i  (w_rst_n),
      .Stall_i    (w_stall),
      .Redirect_i (w_redir),
      .Target_i   (w_target),
      .ImemReq_o  (w_req),
      .ImemAddr_o (w_addr),
      .ImemAck_i  (w_ack),
      .ImemData_i (w_data),
      .PC4_o      (w_pc4),
      .Inst_o     (w_inst),
      .Valid_o    (w_valid)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        redir;
      logic [31:0] target;
      logic        ack;
      logic [31:0] data;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc4;
      logic [31:0] exp_inst;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs[NV];

   // instruction memory contents
   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == 32'd4) return 32'h2002_0005;
      return 32'hC0DE_0000 ^ a;
   endfunction

   function automatic vec_t mk(input logic r, input logic s, input logic rd,
                               input logic [31:0] t, input logic a,
                               input logic [31:0] d, input logic er,
                               input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ei);
      vec_t v;
      v.rst_n = r;  v.stall = s; v.redir = rd; v.target = t;
      v.ack = a;    v.data = d;
      v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev;
      v.exp_pc4 = ep; v.exp_inst = ei;
      return v;
   endfunction

   task automatic check32(input string name, input int idx,
                          input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
   endtask

   // driver: apply inputs at negedge, clock one edge, return at next negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n = 1'b0; stall = 1'b0; redir = 1'b0; target = '0; ack = 1'b0; data = '0;
      w_rst_n = 1'b0; w_stall = 1'b0; w_redir = 1'b0; w_target = '0;
      w_ack = 1'b0; w_data = '0;

      //        rst stl rd target        ack data             req addr          v  pc4           inst
      vecs[0]  = mk(1, 0, 0, 32'h0,     0, 32'h0,           1, 32'h0,        0, 32'h0,        32'h0);
      vecs[1]  = mk(1, 0, 0, 32'h0,     1, imem(32'h0),     0, 32'h0,        1, 32'h4,        imem(32'h0));
      vecs[2]  = mk(1, 0, 0, 32'h0,     0, 32'h0,           1, 32'h4,        0, 32'h4,        imem(32'h0));
      vecs[3]  = mk(1, 0, 0, 32'h0,     1, imem(32'h4),     0, 32'h4,        1, 32'h8,        32'h2002_0005);
      for (int i = 4; i <= 8; i++)
         vecs[i] = mk(1, 1, 0, 32'h0,   0, 32'h0,           0, 32'h4,        1, 32'h8,        32'h2002_0005);
      vecs[9]  = mk(1, 0, 0, 32'h0,     0, 32'h0,           1, 32'h8,        0, 32'h8,        32'h2002_0005);
      vecs[10] = mk(1, 0, 0, 32'h0,     1, imem(32'h8),     0, 32'h8,        1, 32'hC,        imem(32'h8));
      vecs[11] = mk(1, 0, 1, 32'h103,   0, 32'h0,           1, 32'h100,      0, 32'h0,        32'h0);
      vecs[12] = mk(1, 0, 0, 32'h0,     1, imem(32'h100),   0, 32'h100,      1, 32'h104,      imem(32'h100));
      vecs[13] = mk(1, 0, 1, 32'h10,    0, 32'h0,           1, 32'h10,       0, 32'h0,        32'h0);
      vecs[14] = mk(1, 0, 0, 32'h0,     0, 32'h0,           1, 32'h10,       0, 32'h0,        32'h0);
      vecs[15] = mk(1, 0, 1, 32'h200,   0, 32'h0,           1, 32'h10,       0, 32'h0,        32'h0);
      vecs[16] = mk(1, 0, 1, 32'h300,   0, 32'h0,           1, 32'h10,       0, 32'h0,        32'h0);
      vecs[17] = mk(1, 0, 0, 32'h0,     1, imem(32'h10),    1, 32'h300,      0, 32'h0,        32'h0);
      vecs[18] = mk(1, 0, 1, 32'h42,    1, imem(32'h300),   1, 32'h40,       0, 32'h0,        32'h0);
      vecs[19] = mk(1, 0, 0, 32'h0,     1, imem(32'h40),    0, 32'h40,       1, 32'h44,       imem(32'h40));
      vecs[20] = mk(1, 1, 1, 32'h80,    0, 32'h0,           1, 32'h80,       0, 32'h0,        32'h0);
      vecs[21] = mk(1, 1, 0, 32'h0,     1, imem(32'h80),    0, 32'h80,       1, 32'h84,       imem(32'h80));
      vecs[22] = mk(1, 1, 0, 32'h0,     0, 32'h0,           0, 32'h80,       1, 32'h84,       imem(32'h80));
      vecs[23] = mk(1, 0, 0, 32'h0,     0, 32'h0,           1, 32'h84,       0, 32'h84,       imem(32'h80));
      vecs[24] = mk(1, 0, 0, 32'h0,     0, 32'h0,           1, 32'h84,       0, 32'h84,       imem(32'h80));
      vecs[25] = mk(0, 0, 0, 32'h0,     1, imem(32'h84),    0, 32'h0,        0, 32'h0,        32'h0);
      vecs[26] = mk(1, 0, 0, 32'h0,     0, 32'h0,           1, 32'h0,        0, 32'h0,        32'h0);
      vecs[27] = mk(1, 0, 0, 32'h0,     0, 32'h0,           1, 32'h0,        0, 32'h0,        32'h0);
      vecs[28] = mk(1, 0, 1, 32'h500,   0, 32'h0,           1, 32'h0,        0, 32'h0,        32'h0);
      vecs[29] = mk(1, 0, 1, 32'h603,   1, imem(32'h0),     1, 32'h600,      0, 32'h0,        32'h0);
      vecs[30] = mk(1, 0, 0, 32'h0,     1, imem(32'h600),   0, 32'h600,      1, 32'h604,      imem(32'h600));

      // reset state
      @(negedge clk);
      step();
      check32("rst_req",   -1, {31'd0, req},   32'd0);
      check32("rst_addr",  -1, addr,           32'd0);
      check32("rst_valid", -1, {31'd0, valid}, 32'd0);
      check32("rst_pc4",   -1, pc4,            32'd0);
      check32("rst_inst",  -1, inst,           32'd0);

      // table-driven main sequence
      for (int i = 0; i < NV; i++) begin
         rst_n  = vecs[i].rst_n;
         stall  = vecs[i].stall;
         redir  = vecs[i].redir;
         target = vecs[i].target;
         ack    = vecs[i].ack;
         data   = vecs[i].data;
         step();
         check32("req",   i, {31'd0, req},   {31'd0, vecs[i].exp_req});
         check32("addr",  i, addr,           vecs[i].exp_addr);
         check32("valid", i, {31'd0, valid}, {31'd0, vecs[i].exp_valid});
         check32("pc4",   i, pc4,            vecs[i].exp_pc4);
         check32("inst",  i, inst,           vecs[i].exp_inst);
      end
      ack = 1'b0; redir = 1'b0; stall = 1'b0;

      // wrap-around instance: RESET_PC = FFFF_FFFC
      w_rst_n = 1'b1;
      step();
      check32("wrap_req0",  100, {31'd0, w_req}, 32'd1);
      check32("wrap_addr0", 100, w_addr,         32'hFFFF_FFFC);
      w_ack = 1'b1; w_data = 32'h1234_5678;
      step();
      check32("wrap_valid", 101, {31'd0, w_valid}, 32'd1);
      check32("wrap_pc4",   101, w_pc4,            32'h0);
      check32("wrap_inst",  101, w_inst,           32'h1234_5678);
      w_ack = 1'b0;
      step();
      check32("wrap_req1",  102, {31'd0, w_req}, 32'd1);
      check32("wrap_addr1", 102, w_addr,         32'h0);
      check32("wrap_vld1",  102, {31'd0, w_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
